// File: rtl/printer_job_scheduler.sv
// Page-granular round-robin arbiter sharing one printer among N requesters.
// Each owner prints up to QUANTUM pages per turn; preempted jobs resume from saved counts.
module printer_job_scheduler #(
  parameter int unsigned N       = 3,
  parameter int unsigned PW      = 8,
  parameter int unsigned QUANTUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*PW-1:0]      pages_in,
  input  logic                 page_done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 page_start,
  output logic [N-1:0]         done,
  output logic                 busy
);
  localparam int unsigned IDW = $clog2(N);
  localparam logic [PW-1:0] QMAX = PW'(QUANTUM);

  typedef enum logic [1:0] {StIdle, StZero, StPrint, StWait} state_e;
  state_e state_q, state_d;

  logic [N-1:0]   grant_q, done_q, loaded_q;
  logic [IDW-1:0] owner_q, rr_q;
  logic [PW-1:0]  rem_q [N];
  logic [PW-1:0]  qcnt_q;

  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [PW-1:0]  eff_cnt, rem_next, qcnt_next;
  logic           others_req, rel_abort, rel_done, rel_preempt;

  function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
    return IDW'(v % N);
  endfunction

  // Rotating priority scan starting at rr_q.
  always_comb begin : arbiter
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!arb_found && req[wrap_idx(32'(rr_q) + k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(32'(rr_q) + k);
      end
    end
    eff_cnt = loaded_q[arb_idx] ? rem_q[arb_idx] : pages_in[arb_idx*PW +: PW];
  end

  // Release decision is made from the post-page values, applied on page_done.
  always_comb begin : decide
    rem_next    = (rem_q[owner_q] != '0) ? rem_q[owner_q] - PW'(1) : '0;
    qcnt_next   = (qcnt_q < QMAX) ? qcnt_q + PW'(1) : qcnt_q;
    others_req  = |(req & ~grant_q);
    rel_abort   = !req[owner_q];
    rel_done    = !rel_abort && (rem_next == '0);
    rel_preempt = !rel_abort && !rel_done && (qcnt_next == QMAX) && others_req;
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      StIdle:  if (arb_found) state_d = (eff_cnt == '0) ? StZero : StPrint;
      StZero:  state_d = StIdle;
      StPrint: state_d = StWait;
      StWait: begin
        if (page_done) state_d = (rel_abort || rel_done || rel_preempt) ? StIdle : StPrint;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      grant_q  <= '0;
      done_q   <= '0;
      loaded_q <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      qcnt_q   <= '0;
      for (int i = 0; i < N; i++) rem_q[i] <= '0;
    end else begin
      done_q <= '0;
      // A waiting requester that withdraws forfeits its saved count.
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !grant_q[i]) loaded_q[i] <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (arb_found) begin
            grant_q <= N'(1) << arb_idx;
            owner_q <= arb_idx;
            rr_q    <= (arb_idx == IDW'(N - 1)) ? '0 : arb_idx + IDW'(1);
            qcnt_q  <= '0;
            if (eff_cnt == '0) begin
              done_q[arb_idx]   <= 1'b1;
              loaded_q[arb_idx] <= 1'b0;
            end else if (!loaded_q[arb_idx]) begin
              rem_q[arb_idx]    <= pages_in[arb_idx*PW +: PW];
              loaded_q[arb_idx] <= 1'b1;
            end
          end
        end
        StZero: grant_q <= '0;
        StWait: begin
          if (page_done) begin
            rem_q[owner_q] <= rem_next;
            qcnt_q         <= qcnt_next;
            if (rel_abort) begin
              grant_q           <= '0;
              loaded_q[owner_q] <= 1'b0;
            end else if (rel_done) begin
              grant_q           <= '0;
              done_q            <= grant_q;
              loaded_q[owner_q] <= 1'b0;
            end else if (rel_preempt) begin
              grant_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    grant      = grant_q;
    done       = done_q;
    busy       = |grant_q;
    grant_id   = busy ? owner_q : '0;
    page_start = (state_q == StPrint);
  end

endmodule

// File: tb/tb_printer_job_scheduler.sv
// Directed bench for printer_job_scheduler: a simple printer model answers each
// page_start with page_done two cycles later, and per-test tasks check the traces.
module tb_printer_job_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] pages_in;
  logic        page_done;
  logic [2:0]  grant;
  logic [1:0]  grant_id;
  logic        page_start;
  logic [2:0]  done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned ps_q[$], dn_q[$], own_q[$], gap_q[$];
  int busy_cnt, done_cyc, done_busy, timed_out, abort_k, abort_bit;
  bit noise_ps;

  printer_job_scheduler #(.N(3), .PW(8), .QUANTUM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pages_in   (pages_in),
    .page_done  (page_done),
    .grant      (grant),
    .grant_id   (grant_id),
    .page_start (page_start),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encodes a trace as hex digits (entry+1), oldest first.
  function automatic logic [31:0] enc(input int unsigned q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = (v << 4) | 32'(q[i] + 1);
    return v;
  endfunction

  task automatic set_pages(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    pages_in = {p2, p1, p0};
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; page_done = 1'b0; noise_ps = 1'b0; abort_k = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Printer model plus trace recorder; requesters drop req on their done pulse.
  task automatic run(input int max_cyc);
    int pd_cd = 0;
    int gap = 0;
    bit prev_busy = 1'b0;
    bit started = 1'b0;
    bit finished = 1'b0;
    ps_q.delete(); dn_q.delete(); own_q.delete(); gap_q.delete();
    busy_cnt = 0; done_cyc = -1; done_busy = 0; timed_out = 0;
    for (int c = 1; c <= max_cyc && !finished; c++) begin
      tick();
      page_done = 1'b0;
      if (pd_cd > 0) begin
        pd_cd--;
        if (pd_cd == 0) page_done = 1'b1;
      end
      if (abort_k > 0 && ps_q.size() == abort_k && pd_cd == 1) begin
        req[abort_bit] = 1'b0;
        abort_k = 0;
      end
      if (page_start) begin
        ps_q.push_back(grant_id);
        pd_cd = 2;
        if (noise_ps) page_done = 1'b1;
      end
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) begin
          if (started) gap_q.push_back(gap);
          own_q.push_back(grant_id);
          started = 1'b1;
        end
        gap = 0;
      end else begin
        gap++;
      end
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          dn_q.push_back(i);
          done_cyc = c;
          if (busy) done_busy++;
          req[i] = 1'b0;
        end
      end
      prev_busy = busy;
      if (req == '0 && !busy && pd_cd == 0 && !page_done) finished = 1'b1;
    end
    if (!finished) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; page_done = 1'b0; set_pages(8'd1, 8'd1, 8'd1);
    for (int c = 0; c < 2; c++) begin
      req = 3'($urandom_range(7, 1));
      tick();
      n_checks++;
      if (grant !== 3'b000) begin
        n_errors++; $display("FAIL reset_grant: got %b, expected 000", grant);
      end
      n_checks++;
      if (page_start !== 1'b0) begin
        n_errors++; $display("FAIL reset_page_start: got %b, expected 0", page_start);
      end
      n_checks++;
      if (done !== 3'b000) begin
        n_errors++; $display("FAIL reset_done: got %b, expected 000", done);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy);
      end
    end
    rst = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_single_job();
    do_reset();
    set_pages(8'd3, 8'd0, 8'd0);
    req = 3'b001;
    run(100);
    n_checks++;
    if (timed_out !== 0) begin
      n_errors++; $display("FAIL single_timeout: got %0d, expected 0", timed_out);
    end
    n_checks++;
    if (enc(ps_q) !== 32'h111) begin
      n_errors++; $display("FAIL single_pages: got %h, expected 111", enc(ps_q));
    end
    n_checks++;
    if (enc(own_q) !== 32'h1) begin
      n_errors++; $display("FAIL single_owners: got %h, expected 1", enc(own_q));
    end
    n_checks++;
    if (enc(dn_q) !== 32'h1) begin
      n_errors++; $display("FAIL single_done: got %h, expected 1", enc(dn_q));
    end
    n_checks++;
    if (done_cyc !== 10) begin
      n_errors++; $display("FAIL single_done_cycle: got %0d, expected 10", done_cyc);
    end
    n_checks++;
    if (busy_cnt !== 9) begin
      n_errors++; $display("FAIL single_busy_cycles: got %0d, expected 9", busy_cnt);
    end
    n_checks++;
    if (done_busy !== 0) begin
      n_errors++; $display("FAIL single_done_with_grant: got %0d, expected 0", done_busy);
    end
  endtask

  task automatic test_quantum_preempt();
    do_reset();
    set_pages(8'd6, 8'd2, 8'd0);
    req = 3'b011;
    run(200);
    n_checks++;
    if (timed_out !== 0) begin
      n_errors++; $display("FAIL quantum_timeout: got %0d, expected 0", timed_out);
    end
    n_checks++;
    if (enc(ps_q) !== 32'h11112211) begin
      n_errors++; $display("FAIL quantum_pages: got %h, expected 11112211", enc(ps_q));
    end
    n_checks++;
    if (enc(own_q) !== 32'h121) begin
      n_errors++; $display("FAIL quantum_owners: got %h, expected 121", enc(own_q));
    end
    n_checks++;
    if (enc(dn_q) !== 32'h21) begin
      n_errors++; $display("FAIL quantum_done: got %h, expected 21", enc(dn_q));
    end
    n_checks++;
    if (enc(gap_q) !== 32'h22) begin
      n_errors++; $display("FAIL quantum_gaps: got %h, expected 22", enc(gap_q));
    end
  endtask

  task automatic test_rotation();
    do_reset();
    set_pages(8'd1, 8'd1, 8'd1);
    for (int r = 0; r < 2; r++) begin
      req = 3'b111;
      run(100);
      n_checks++;
      if (timed_out !== 0) begin
        n_errors++; $display("FAIL rotation_timeout[%0d]: got %0d, expected 0", r, timed_out);
      end
      n_checks++;
      if (enc(ps_q) !== 32'h123) begin
        n_errors++; $display("FAIL rotation_pages[%0d]: got %h, expected 123", r, enc(ps_q));
      end
      n_checks++;
      if (enc(own_q) !== 32'h123) begin
        n_errors++; $display("FAIL rotation_owners[%0d]: got %h, expected 123", r, enc(own_q));
      end
      n_checks++;
      if (enc(dn_q) !== 32'h123) begin
        n_errors++; $display("FAIL rotation_done[%0d]: got %h, expected 123", r, enc(dn_q));
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    set_pages(8'd0, 8'd5, 8'd0);
    req = 3'b010;
    abort_k = 2; abort_bit = 1;
    run(100);
    n_checks++;
    if (enc(ps_q) !== 32'h22) begin
      n_errors++; $display("FAIL abort_pages: got %h, expected 22", enc(ps_q));
    end
    n_checks++;
    if (dn_q.size() !== 0) begin
      n_errors++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", dn_q.size());
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_released: got busy=%b, expected 0", busy);
    end
    set_pages(8'd0, 8'd2, 8'd0);
    req = 3'b010;
    run(100);
    n_checks++;
    if (enc(ps_q) !== 32'h22) begin
      n_errors++; $display("FAIL abort_reload_pages: got %h, expected 22", enc(ps_q));
    end
    n_checks++;
    if (enc(dn_q) !== 32'h2) begin
      n_errors++; $display("FAIL abort_reload_done: got %h, expected 2", enc(dn_q));
    end
  endtask

  task automatic test_zero_and_noise();
    do_reset();
    set_pages(8'd0, 8'd0, 8'd0);
    req = 3'b001;
    run(20);
    n_checks++;
    if (ps_q.size() !== 0) begin
      n_errors++; $display("FAIL zero_no_page_start: got %0d, expected 0", ps_q.size());
    end
    n_checks++;
    if (enc(dn_q) !== 32'h1) begin
      n_errors++; $display("FAIL zero_done: got %h, expected 1", enc(dn_q));
    end
    n_checks++;
    if (done_busy !== 1 || busy_cnt !== 1) begin
      n_errors++;
      $display("FAIL zero_grant_with_done: got done_busy=%0d busy=%0d, expected 1 1",
               done_busy, busy_cnt);
    end
    do_reset();
    page_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({busy, page_start, done} !== 5'b0) begin
        n_errors++;
        $display("FAIL idle_noise: got busy=%b ps=%b done=%b, expected all 0",
                 busy, page_start, done);
      end
    end
    page_done = 1'b0;
    noise_ps = 1'b1;
    set_pages(8'd2, 8'd0, 8'd0);
    req = 3'b001;
    run(100);
    noise_ps = 1'b0;
    n_checks++;
    if (enc(ps_q) !== 32'h11) begin
      n_errors++; $display("FAIL noise_pages: got %h, expected 11", enc(ps_q));
    end
    n_checks++;
    if (enc(dn_q) !== 32'h1 || done_cyc !== 7) begin
      n_errors++;
      $display("FAIL noise_done: got %h at cycle %0d, expected 1 at cycle 7", enc(dn_q), done_cyc);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; pages_in = '0; page_done = 1'b0;
    noise_ps = 1'b0; abort_k = 0; abort_bit = 0;
    test_reset();
    test_single_job();
    test_quantum_preempt();
    test_rotation();
    test_abort();
    test_zero_and_noise();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
